// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
//   Bundle between the multi-cycle sequencing controller and its datapath.
//   master : the controller (consumes instruction fields, ALU zero flag and
//            the memory ready; drives datapath strobes, debug state and
//            retired-instruction count).
//   slave  : the datapath / environment side (the mirror image).
//
//   Handshake: a memory access (MemRd or MemWr high) completes on the
//   rising clock edge where mem_ready is also high. Until then the
//   controller holds the same strobes and state. There is no valid/ready
//   pairing beyond that; every other strobe is a plain per-cycle enable.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       func;
    logic             zero;
    logic             mem_ready;

    logic             PCWr;
    logic             PCWrCond;
    logic             pc_en;
    logic [1:0]       PCSrc;
    logic             IorD;
    logic             MemRd;
    logic             MemWr;
    logic             IRWr;
    logic             RegDst;
    logic             MemtoReg;
    logic             RegWr;
    logic             ExtOp;
    logic             ALUsrcA;
    logic [1:0]       ALUsrcB;
    logic [2:0]       ALUctr;
    logic             halted;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  op, func, zero, mem_ready,
        output PCWr, PCWrCond, pc_en, PCSrc, IorD, MemRd, MemWr, IRWr,
               RegDst, MemtoReg, RegWr, ExtOp, ALUsrcA, ALUsrcB, ALUctr,
               halted, state, instr_cnt
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  PCWr, PCWrCond, pc_en, PCSrc, IorD, MemRd, MemWr, IRWr,
               RegDst, MemtoReg, RegWr, ExtOp, ALUsrcA, ALUsrcB, ALUctr,
               halted, state, instr_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle sequencing controller for the MIPS subset
//   add/sub/and/or/slt/lw/sw/beq/j. Walks each instruction through
//   fetch/decode/execute/memory/write-back states and drives the per-state
//   strobes of a shared-ALU, unified-memory datapath. Halts on illegal
//   encodings and counts retired instructions.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (state -> FETCH, count -> 0)
//   bus    : multicycle_ctrl_if.master (instruction fields, zero flag,
//            mem_ready in; datapath strobes, state, halted, instr_cnt out)
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_LW_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EX     = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BEQ_EX   = 4'd8;
    localparam logic [3:0] S_J_EX     = 4'd9;
    localparam logic [3:0] S_HALT     = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_next;
    logic             w_retire;
    logic             w_func_ok;
    logic [2:0]       w_func_alu;

    // R-type function decode: legality and ALU operation in one table.
    always_comb begin
        w_func_ok  = 1'b1;
        w_func_alu = 3'b000;
        case (bus.func)
            6'h20:   w_func_alu = 3'b000;
            6'h22:   w_func_alu = 3'b001;
            6'h24:   w_func_alu = 3'b010;
            6'h25:   w_func_alu = 3'b011;
            6'h2A:   w_func_alu = 3'b100;
            default: w_func_ok  = 1'b0;
        endcase
    end

    // Next-state logic. Unused codes 10..14 fall back to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (bus.op == OP_LW || bus.op == OP_SW)     w_next = S_MEM_ADDR;
                else if (bus.op == OP_RTYPE && w_func_ok)   w_next = S_R_EX;
                else if (bus.op == OP_BEQ)                  w_next = S_BEQ_EX;
                else if (bus.op == OP_J)                    w_next = S_J_EX;
                else                                        w_next = S_HALT;
            end
            S_MEM_ADDR: begin
                if (bus.op == OP_LW)      w_next = S_MEM_RD;
                else if (bus.op == OP_SW) w_next = S_MEM_WR;
                else                      w_next = S_FETCH;
            end
            S_MEM_RD: w_next = bus.mem_ready ? S_LW_WB : S_MEM_RD;
            S_LW_WB:  w_next = S_FETCH;
            S_MEM_WR: w_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EX:   w_next = S_R_WB;
            S_R_WB:   w_next = S_FETCH;
            S_BEQ_EX: w_next = S_FETCH;
            S_J_EX:   w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its last state; a store
    // retires only on the edge where memory accepts the write.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_LW_WB, S_R_WB, S_BEQ_EX, S_J_EX: w_retire = 1'b1;
            S_MEM_WR:                          w_retire = bus.mem_ready;
            default:                           w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Moore-style strobe decode from the state register. The fetch write
    // strobes are additionally qualified by rst_n so that nothing is written
    // while reset is held, even if memory reports ready.
    always_comb begin
        bus.PCWr     = 1'b0;
        bus.PCWrCond = 1'b0;
        bus.PCSrc    = 2'b00;
        bus.IorD     = 1'b0;
        bus.MemRd    = 1'b0;
        bus.MemWr    = 1'b0;
        bus.IRWr     = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWr    = 1'b0;
        bus.ExtOp    = 1'b0;
        bus.ALUsrcA  = 1'b0;
        bus.ALUsrcB  = 2'b00;
        bus.ALUctr   = 3'b000;
        case (r_state)
            S_FETCH: begin
                bus.MemRd   = 1'b1;
                bus.ALUsrcB = 2'b01;
                bus.IRWr    = bus.mem_ready & rst_n;
                bus.PCWr    = bus.mem_ready & rst_n;
            end
            S_DECODE: begin
                bus.ALUsrcB = 2'b11;
                bus.ExtOp   = 1'b1;
            end
            S_MEM_ADDR: begin
                bus.ALUsrcA = 1'b1;
                bus.ALUsrcB = 2'b10;
                bus.ExtOp   = 1'b1;
            end
            S_MEM_RD: begin
                bus.MemRd = 1'b1;
                bus.IorD  = 1'b1;
            end
            S_LW_WB: begin
                bus.RegWr    = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                bus.MemWr = 1'b1;
                bus.IorD  = 1'b1;
            end
            S_R_EX: begin
                bus.ALUsrcA = 1'b1;
                bus.ALUctr  = w_func_alu;
            end
            S_R_WB: begin
                bus.RegWr  = 1'b1;
                bus.RegDst = 1'b1;
            end
            S_BEQ_EX: begin
                bus.ALUsrcA  = 1'b1;
                bus.ALUctr   = 3'b001;
                bus.PCWrCond = 1'b1;
                bus.PCSrc    = 2'b01;
            end
            S_J_EX: begin
                bus.PCWr  = 1'b1;
                bus.PCSrc = 2'b10;
            end
            default: ;
        endcase
    end

    // Branch resolution uses the live zero flag, so pc_en is combinational.
    assign bus.pc_en     = bus.PCWr | (bus.PCWrCond & bus.zero);
    assign bus.halted    = (r_state == S_HALT);
    assign bus.state     = r_state;
    assign bus.instr_cnt = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] cnt;
    logic       pcwr;
    logic       pcwrcond;
    logic       pc_en;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memrd;
    logic       memwr;
    logic       irwr;
    logic       regdst;
    logic       memtoreg;
    logic       regwr;
    logic       extop;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluctr;
    logic       halted;
  } exp_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic       mr;
    logic       z;
    exp_t       e;
  } step_t;

  logic clk;
  logic rst_n;

  multicycle_ctrl_if #(.CNT_W(4)) bus ();

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  step_t plan_q[$];
  exp_t  exp_q[$];
  int    n_cmp;
  int    n_fail;
  int    m_cnt;

  function automatic exp_t actual();
    exp_t a;
    a.st       = bus.state;
    a.cnt      = bus.instr_cnt;
    a.pcwr     = bus.PCWr;
    a.pcwrcond = bus.PCWrCond;
    a.pc_en    = bus.pc_en;
    a.pcsrc    = bus.PCSrc;
    a.iord     = bus.IorD;
    a.memrd    = bus.MemRd;
    a.memwr    = bus.MemWr;
    a.irwr     = bus.IRWr;
    a.regdst   = bus.RegDst;
    a.memtoreg = bus.MemtoReg;
    a.regwr    = bus.RegWr;
    a.extop    = bus.ExtOp;
    a.srca     = bus.ALUsrcA;
    a.srcb     = bus.ALUsrcB;
    a.aluctr   = bus.ALUctr;
    a.halted   = bus.halted;
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // reference model: everything idle except the state and current count
  function automatic exp_t base(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.cnt = m_cnt[3:0];
    return e;
  endfunction

  task automatic add_step(input logic [5:0] op, input logic [5:0] func,
                          input logic mr, input logic z, input exp_t e);
    step_t s;
    s.op = op;
    s.func = func;
    s.mr = mr;
    s.z = z;
    s.e = e;
    plan_q.push_back(s);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expands one instruction into its expected cycle-by-cycle behaviour.
  // fs = wait cycles in fetch, ms = wait cycles in the data access.
  task automatic gen_instr(input logic [5:0] op, input logic [5:0] func,
                           input logic z, input int fs, input int ms);
    exp_t e;
    logic [2:0] alu;
    bit r_ok;
    r_ok = 1'b1;
    alu = 3'b000;
    case (func)
      6'h20: alu = 3'd0;
      6'h22: alu = 3'd1;
      6'h24: alu = 3'd2;
      6'h25: alu = 3'd3;
      6'h2A: alu = 3'd4;
      default: r_ok = 1'b0;
    endcase
    for (int i = 0; i < fs; i++) begin
      e = base(4'd0); e.memrd = 1; e.srcb = 2'b01;
      add_step(op, func, 1'b0, rnd_bit(), e);
    end
    e = base(4'd0); e.memrd = 1; e.srcb = 2'b01; e.irwr = 1; e.pcwr = 1; e.pc_en = 1;
    add_step(op, func, 1'b1, rnd_bit(), e);
    e = base(4'd1); e.srcb = 2'b11; e.extop = 1;
    add_step(op, func, rnd_bit(), rnd_bit(), e);
    if (op == 6'h23 || op == 6'h2B) begin
      e = base(4'd2); e.srca = 1; e.srcb = 2'b10; e.extop = 1;
      add_step(op, func, rnd_bit(), rnd_bit(), e);
      if (op == 6'h23) begin
        for (int i = 0; i <= ms; i++) begin
          e = base(4'd3); e.memrd = 1; e.iord = 1;
          add_step(op, func, (i == ms), rnd_bit(), e);
        end
        e = base(4'd4); e.regwr = 1; e.memtoreg = 1;
        add_step(op, func, rnd_bit(), rnd_bit(), e);
      end else begin
        for (int i = 0; i <= ms; i++) begin
          e = base(4'd5); e.memwr = 1; e.iord = 1;
          add_step(op, func, (i == ms), rnd_bit(), e);
        end
      end
      m_cnt++;
    end else if (op == 6'h00 && r_ok) begin
      e = base(4'd6); e.srca = 1; e.aluctr = alu;
      add_step(op, func, rnd_bit(), rnd_bit(), e);
      e = base(4'd7); e.regwr = 1; e.regdst = 1;
      add_step(op, func, rnd_bit(), rnd_bit(), e);
      m_cnt++;
    end else if (op == 6'h04) begin
      e = base(4'd8); e.srca = 1; e.aluctr = 3'd1; e.pcwrcond = 1; e.pcsrc = 2'b01; e.pc_en = z;
      add_step(op, func, rnd_bit(), z, e);
      m_cnt++;
    end else if (op == 6'h02) begin
      e = base(4'd9); e.pcwr = 1; e.pcsrc = 2'b10; e.pc_en = 1;
      add_step(op, func, rnd_bit(), rnd_bit(), e);
      m_cnt++;
    end else begin
      for (int i = 0; i < 20; i++) begin
        e = base(4'd15); e.halted = 1;
        add_step(op, func, rnd_bit(), rnd_bit(), e);
      end
    end
  endtask

  // monitor / scoreboard: one expected record per cycle
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle @%0t: got state=%0d cnt=%0d strobes=%h, expected state=%0d cnt=%0d strobes=%h",
                 $time, a.st, a.cnt, a[19:0], e.st, e.cnt, e[19:0]);
      end
      n_cmp++;
      if ((32'(bus.RegWr) + 32'(bus.MemWr) + 32'(bus.IRWr)) > 1) begin
        n_fail++;
        $display("FAIL write_exclusive @%0t: got RegWr/MemWr/IRWr=%b%b%b, expected at most one",
                 $time, bus.RegWr, bus.MemWr, bus.IRWr);
      end
    end
  end

  logic [5:0] rfuncs [5];

  initial begin
    step_t s;
    int k;
    n_cmp = 0;
    n_fail = 0;
    m_cnt = 0;
    rfuncs[0] = 6'h20; rfuncs[1] = 6'h22; rfuncs[2] = 6'h24;
    rfuncs[3] = 6'h25; rfuncs[4] = 6'h2A;
    rst_n = 1'b0;
    bus.op = 6'h00;
    bus.func = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;

    #23;
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_memrd", 32'(bus.MemRd), 32'd1);
    check("reset_irwr", 32'(bus.IRWr), 32'd0);
    check("reset_pcwr", 32'(bus.PCWr), 32'd0);
    check("reset_cnt", 32'(bus.instr_cnt), 32'd0);
    check("reset_halted", 32'(bus.halted), 32'd0);
    check("reset_srcb", 32'(bus.ALUsrcB), 32'd1);
    rst_n = 1'b1;

    // directed stream, then R-type variants, branches, stalled store
    gen_instr(6'h00, 6'h20, 1'b0, 2, 0);
    gen_instr(6'h23, 6'h11, 1'b0, 0, 0);
    gen_instr(6'h2B, 6'h05, 1'b0, 0, 0);
    gen_instr(6'h04, 6'h00, 1'b1, 0, 0);
    gen_instr(6'h02, 6'h3C, 1'b0, 0, 0);
    gen_instr(6'h00, 6'h22, 1'b0, 0, 0);
    gen_instr(6'h00, 6'h24, 1'b0, 0, 0);
    gen_instr(6'h00, 6'h25, 1'b0, 0, 0);
    gen_instr(6'h00, 6'h2A, 1'b0, 0, 0);
    gen_instr(6'h04, 6'h00, 1'b1, 0, 0);
    gen_instr(6'h04, 6'h00, 1'b0, 0, 0);
    gen_instr(6'h2B, 6'h00, 1'b0, 1, 3);
    // random legal mix, wraps the 4-bit counter several times
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 4);
      case (k)
        0: gen_instr(6'h00, rfuncs[$urandom_range(0, 4)], rnd_bit(), $urandom_range(0, 2), 0);
        1: gen_instr(6'h23, 6'($urandom), rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 3));
        2: gen_instr(6'h2B, 6'($urandom), rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 3));
        3: gen_instr(6'h04, 6'($urandom), rnd_bit(), $urandom_range(0, 2), 0);
        default: gen_instr(6'h02, 6'($urandom), rnd_bit(), $urandom_range(0, 2), 0);
      endcase
    end
    gen_instr(6'h3F, 6'h00, 1'b0, 0, 0);

    // driver
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      @(posedge clk);
      #1;
      bus.op = s.op;
      bus.func = s.func;
      bus.mem_ready = s.mr;
      bus.zero = s.z;
      exp_q.push_back(s.e);
    end

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_timeout", 32'(exp_q.size()), 32'd0);

    #1;
    bus.mem_ready = 1'b0;
    check("halt_held", 32'(bus.halted), 32'd1);
    check("halt_cnt", 32'(bus.instr_cnt), 32'(m_cnt % 16));
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(bus.state), 32'd0);
    check("async_rst_cnt", 32'(bus.instr_cnt), 32'd0);
    check("async_rst_halted", 32'(bus.halted), 32'd0);
    check("async_rst_memrd", 32'(bus.MemRd), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(bus.state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
